pc_sequencer: RTL

//  Program-counter sequencer for the 9-bit accumulator core.

---
 rtl/pc_sequencer_if.sv | 48 ++++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_sequencer_if                                            |
// | Description : Bus between the program-counter sequencer and its host     |
// |               (control decoder, instruction memory, LUT loader).         |
// |               Signals:                                                   |
// |                 start          host -> seq  begin program                |
// |                 inst           host -> seq  instruction at current pc    |
// |                 branch_en      host -> seq  branch taken this cycle      |
// |                 memory_read_en host -> seq  load issued this cycle       |
// |                 lut_we/addr/data host -> seq branch-target LUT write     |
// |                 pc             seq -> host  instruction-memory address   |
// |                 stall          seq -> host  suppress reg_write_en        |
// |                 busy / done    seq -> host  run status                   |
// |                 cycle_count    seq -> host  cycles spent running         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int KEY_W = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic [8:0]       inst;
  logic             branch_en;
  logic             memory_read_en;
  logic             lut_we;
  logic [KEY_W-1:0] lut_addr;
  logic [PC_W-1:0]  lut_data;
  logic [PC_W-1:0]  pc;
  logic             stall;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  // Host side (control decoder / memory / test driver)
  modport master (
    output start, inst, branch_en, memory_read_en, lut_we, lut_addr, lut_data,
    input  pc, stall, busy, done, cycle_count
  );

  // Sequencer side
  modport slave (
    input  start, inst, branch_en, memory_read_en, lut_we, lut_addr, lut_data,
    output pc, stall, busy, done, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_sequencer                                               |
// | Description : Program-counter sequencer for the 9-bit accumulator core.  |
// |               Steps the instruction address, resolves branch keys via a  |
// |               writable target LUT, stalls register writes during         |
// |               multi-cycle loads and reports done plus a cycle count.     |
// |               Ports:                                                     |
// |                 clk    in  rising-edge clock                             |
// |                 rst_n  in  asynchronous active-low reset                 |
// |                 bus    slave modport of pc_sequencer_if                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int KEY_W    = 5,
  parameter int MEM_LAT  = 1,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  localparam int LUT_D = 2 ** KEY_W;
  // Load wait counter only needs to hold MEM_LAT-1.
  localparam int CW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [8:0]       C_HALT     = 9'h1FF;
  localparam logic [CW-1:0]    C_LAT_M1   = CW'(MEM_LAT - 1);
  localparam logic [PC_W-1:0]  C_START_PC = PC_W'(START_PC);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [PC_W-1:0]  lut_q [LUT_D];

  logic             stall;
  logic             is_halt;
  logic [PC_W-1:0]  branch_target;
  logic [CNT_W-1:0] cycle_count_inc;

  assign is_halt         = (bus.inst == C_HALT);
  // Read of the registered LUT: a same-cycle write lands only at the clock
  // edge, so a simultaneous lookup of the same key sees the old target.
  assign branch_target   = lut_q[bus.inst[KEY_W-1:0]];
  assign cycle_count_inc = (cycle_count_q == C_CNT_MAX) ? cycle_count_q
                                                        : cycle_count_q + CNT_W'(1);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    cycle_count_d = cycle_count_q;
    stall         = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          pc_d          = C_START_PC;
          cycle_count_d = '0;
        end
      end

      ST_RUN: begin
        cycle_count_d = cycle_count_inc;
        if (is_halt) begin
          // pc stays on the HALT word
          state_d = ST_DONE;
        end else if (bus.memory_read_en) begin
          stall   = 1'b1;
          cnt_d   = C_LAT_M1;
          state_d = ST_MEM_WAIT;
        end else if (bus.branch_en) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      ST_MEM_WAIT: begin
        cycle_count_d = cycle_count_inc;
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Load data returns this cycle; the register write goes ahead.
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= C_START_PC;
      cnt_q         <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Branch-target LUT, writable in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_D; i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.lut_we) begin
      lut_q[bus.lut_addr] <= bus.lut_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc          = pc_q;
  assign bus.stall       = stall;
  assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.cycle_count = cycle_count_q;

endmodule
`default_nettype wire
